// File: rtl/ldpc_llr_loader.sv
// Frame loader: fills an R*D LLR buffer one sample per cycle, pulses en to the core, then waits for done.
// Optional saturation when LDPC_LLR_SAT_EN is defined; otherwise the sample is truncated to data_w bits.
module ldpc_llr_loader #(
  parameter int data_w = 5,
  parameter int in_w   = 8,
  parameter int R      = 24,
  parameter int D      = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [in_w-1:0]          in_data,
  output logic                     in_ready,
  input  logic [1:0]               status,
  output logic [R*D*data_w-1:0]    sig,
  output logic                     en,
  output logic [7:0]               frame_cnt
);

  localparam int N  = R * D;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IW-1:0]         r_idx;
  logic [N*data_w-1:0]   r_sig;
  logic                  r_en;
  logic [7:0]            r_frame_cnt;
  logic [data_w-1:0]     w_llr;
  logic                  w_acc;
  logic                  w_last;

`ifdef LDPC_LLR_SAT_EN
  localparam logic signed [in_w-1:0] SAT_HI = in_w'((2 ** (data_w - 1)) - 1);
  localparam logic signed [in_w-1:0] SAT_LO = ~SAT_HI;

  always_comb begin
    if ($signed(in_data) > SAT_HI) begin
      w_llr = SAT_HI[data_w-1:0];
    end else if ($signed(in_data) < SAT_LO) begin
      w_llr = SAT_LO[data_w-1:0];
    end else begin
      w_llr = in_data[data_w-1:0];
    end
  end
`else
  assign w_llr = in_data[data_w-1:0];
`endif

  assign in_ready  = (r_state == FILL);
  assign w_acc     = in_valid && in_ready;
  assign w_last    = w_acc && (r_idx == LAST);
  assign sig       = r_sig;
  assign en        = r_en;
  assign frame_cnt = r_frame_cnt;

  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL:    if (w_last) w_next = START;
      START:   w_next = WAIT;
      WAIT:    if (status == 2'd1) w_next = FILL;
      default: w_next = FILL;
    endcase
  end

  // en is high exactly while in START, since START lasts a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FILL;
      r_idx       <= '0;
      r_sig       <= '0;
      r_en        <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_state <= w_next;
      r_en    <= w_last;
      if (w_acc) begin
        r_sig[r_idx*data_w +: data_w] <= w_llr;
        r_idx <= w_last ? '0 : r_idx + IW'(1);
      end
      if (w_last) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

endmodule
